wash_seq: RTL and testbench

WASH_SEQ -- requirements
Module: wash_seq

---
 rtl/wash_pkg.sv | 30 +++
 rtl/wash_timer.sv | 28 ++
 rtl/wash_seq.sv | 130 +++++++++++++
 tb/tb_wash_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - state encodings, motor codes and decode helpers for wash_seq
package wash_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FWD   = 3'd1;
    localparam state_t ST_STOP1 = 3'd2;
    localparam state_t ST_REV   = 3'd3;
    localparam state_t ST_STOP2 = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_FWD  = 2'b01;
    localparam logic [1:0] MOTOR_REV  = 2'b10;

    function automatic logic [1:0] motor_code(input state_t st);
        case (st)
            ST_FWD:  return MOTOR_FWD;
            ST_REV:  return MOTOR_REV;
            default: return MOTOR_STOP;
        endcase
    endfunction

    // Run and dwell phases; the only states in which pause has any effect.
    function automatic logic is_active(input state_t st);
        return (st == ST_FWD) || (st == ST_STOP1) || (st == ST_REV) || (st == ST_STOP2);
    endfunction

endpackage

// File: rtl/wash_timer.sv
// rtl/wash_timer.sv - phase down-counter with load, enable and zero flag
module wash_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load wins over enable; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wash_seq.sv
// rtl/wash_seq.sv - washing-machine drum sequencer: FWD/STOP/REV/STOP cycles with pause
module wash_seq
    import wash_pkg::*;
#(
    parameter int CLK_FREQ = 1,
    parameter int FWD_SEC  = 3,
    parameter int REV_SEC  = 3,
    parameter int STOP_SEC = 1,
    parameter int N_CYCLES = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    output logic [1:0]       motor,
    output logic             busy,
    output logic             compl_n,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam longint CNT_LIM = longint'(1) << CNT_W;

    generate
        if (CLK_FREQ < 1 || FWD_SEC < 1 || REV_SEC < 1 || STOP_SEC < 1 || N_CYCLES < 1) begin : g_bad_zero
            $error("wash_seq: durations, N_CYCLES and CLK_FREQ must all be non-zero");
        end
        if (longint'(FWD_SEC) * longint'(CLK_FREQ) > CNT_LIM ||
            longint'(REV_SEC) * longint'(CLK_FREQ) > CNT_LIM ||
            longint'(STOP_SEC) * longint'(CLK_FREQ) > CNT_LIM ||
            longint'(N_CYCLES) >= CNT_LIM) begin : g_bad_width
            $error("wash_seq: phase length or cycle count does not fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] FWD_LD  = CNT_W'(FWD_SEC * CLK_FREQ - 1);
    localparam logic [CNT_W-1:0] REV_LD  = CNT_W'(REV_SEC * CLK_FREQ - 1);
    localparam logic [CNT_W-1:0] STOP_LD = CNT_W'(STOP_SEC * CLK_FREQ - 1);
    localparam logic [CNT_W-1:0] N_LIM   = CNT_W'(N_CYCLES);

    state_t           state;
    state_t           nxt_state;
    logic             tmr_load;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic [CNT_W-1:0] cnt_nxt;
    logic             advance;

    wash_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign advance = tmr_zero && !pause;

    always_comb begin
        nxt_state = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = is_active(state) && !pause;
        cnt_nxt   = cycle_cnt;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    nxt_state = ST_FWD;
                    tmr_load  = 1'b1;
                    tmr_val   = FWD_LD;
                    cnt_nxt   = '0;
                end
            end
            ST_FWD: begin
                if (advance) begin
                    nxt_state = ST_STOP1;
                    tmr_load  = 1'b1;
                    tmr_val   = STOP_LD;
                end
            end
            ST_STOP1: begin
                if (advance) begin
                    nxt_state = ST_REV;
                    tmr_load  = 1'b1;
                    tmr_val   = REV_LD;
                end
            end
            ST_REV: begin
                if (advance) begin
                    nxt_state = ST_STOP2;
                    tmr_load  = 1'b1;
                    tmr_val   = STOP_LD;
                end
            end
            ST_STOP2: begin
                if (advance) begin
                    cnt_nxt = cycle_cnt + 1'b1;
                    if (cnt_nxt == N_LIM) begin
                        nxt_state = ST_DONE;
                    end else begin
                        nxt_state = ST_FWD;
                        tmr_load  = 1'b1;
                        tmr_val   = FWD_LD;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            motor     <= MOTOR_STOP;
            busy      <= 1'b0;
            compl_n   <= 1'b1;
            cycle_cnt <= '0;
        end else begin
            state     <= nxt_state;
            motor     <= (pause && is_active(state)) ? MOTOR_STOP : motor_code(nxt_state);
            busy      <= is_active(nxt_state);
            compl_n   <= (nxt_state != ST_DONE);
            cycle_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wash_seq.sv
// tb/tb_wash_seq.sv - scoreboard bench for wash_seq, default and swept configurations
module tb_wash_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;

    logic [1:0]  motor_a, motor_b;
    logic        busy_a, busy_b;
    logic        compl_a, compl_b;
    logic [15:0] cnt_a, cnt_b;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  motor;
        logic        busy;
        logic        compl_n;
        logic [15:0] cnt;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];

    int dur[2][4];
    int ncyc[2];
    bit act[2];
    bit fin[2];
    int ph[2];
    int rem[2];
    int cyc[2];

    wash_seq u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .motor     (motor_a),
        .busy      (busy_a),
        .compl_n   (compl_a),
        .cycle_cnt (cnt_a)
    );

    wash_seq #(.CLK_FREQ(4), .STOP_SEC(2), .N_CYCLES(3)) u_cfg (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .motor     (motor_b),
        .busy      (busy_b),
        .compl_n   (compl_b),
        .cycle_cnt (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s @%0t: got %0d required %0d", name, $time, got, want);
        end
    endtask

    task automatic sb_check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s @%0t: got motor=%b busy=%b compl_n=%b cnt=%0d required motor=%b busy=%b compl_n=%b cnt=%0d",
                     name, $time, got.motor, got.busy, got.compl_n, got.cnt,
                     want.motor, want.busy, want.compl_n, want.cnt);
        end
    endtask

    // Wash as a list of four timed phases repeated ncyc times; rem counts cycles left in the phase.
    task automatic model_step(input int i, input logic st, input logic pz, output obs_t o);
        bit was_act;
        was_act = act[i];
        if (!act[i]) begin
            if (st) begin
                act[i] = 1'b1;
                fin[i] = 1'b0;
                ph[i]  = 0;
                rem[i] = dur[i][0];
                cyc[i] = 0;
            end
        end else if (!pz) begin
            rem[i]--;
            if (rem[i] == 0) begin
                ph[i]++;
                if (ph[i] == 4) begin
                    ph[i] = 0;
                    cyc[i]++;
                end
                if (ph[i] == 0 && cyc[i] == ncyc[i]) begin
                    act[i] = 1'b0;
                    fin[i] = 1'b1;
                end else begin
                    rem[i] = dur[i][ph[i]];
                end
            end
        end
        if (!act[i] || (was_act && pz))
            o.motor = 2'b00;
        else
            o.motor = (ph[i] == 0) ? 2'b01 : (ph[i] == 2) ? 2'b10 : 2'b00;
        o.busy    = act[i];
        o.compl_n = !fin[i];
        o.cnt     = 16'(cyc[i]);
    endtask

    initial begin
        obs_t o;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    act[i] = 1'b0;
                    fin[i] = 1'b0;
                    ph[i]  = 0;
                    rem[i] = 0;
                    cyc[i] = 0;
                end
                q_a.delete();
                q_b.delete();
            end else begin
                model_step(0, start, pause, o);
                q_a.push_back(o);
                model_step(1, start, pause, o);
                q_b.push_back(o);
            end
        end
    end

    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_check("reset_hold_a", {motor_a, busy_a, compl_a, cnt_a}, {2'b00, 1'b0, 1'b1, 16'd0});
                sb_check("reset_hold_b", {motor_b, busy_b, compl_b, cnt_b}, {2'b00, 1'b0, 1'b1, 16'd0});
            end else begin
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    sb_check("scoreboard_a", {motor_a, busy_a, compl_a, cnt_a}, e);
                end
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    sb_check("scoreboard_b", {motor_b, busy_b, compl_b, cnt_b}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // k counts edges after the call; first edge seen is k=1.
    task automatic wait_done(input int limit, output int ka, output int kb);
        ka = -1;
        kb = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (ka < 0 && !compl_a) ka = k;
            if (kb < 0 && !compl_b) kb = k;
            if (ka >= 0 && kb >= 0) break;
        end
    endtask

    initial begin
        int ka, kb;
        bit found;
        dur[0] = '{3, 1, 3, 1};
        dur[1] = '{12, 8, 12, 8};
        ncyc[0] = 2;
        ncyc[1] = 3;

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Full wash from IDLE; start edge E is inside pulse_start.
        pulse_start();
        wait_done(200, ka, kb);
        check("full_wash_done_edge_a", ka, 16);
        check("sweep_done_edge_b", kb, 120);
        check("full_wash_cnt_a", cnt_a, 2);
        check("sweep_cnt_b", cnt_b, 3);
        tick();

        // Pause for four edges after the second FWD cycle.
        pulse_start();
        tick();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pause_motor_a", motor_a, 2'b00);
            check("pause_motor_b", motor_b, 2'b00);
        end
        pause = 1'b0;
        tick();
        check("pause_resume_fwd_a", motor_a, 2'b01);
        tick();
        check("pause_resume_stop1_a", motor_a, 2'b00);
        wait_done(200, ka, kb);
        check("pause_done_edge_a", ka + 7, 20);
        check("pause_done_edge_b", kb + 7, 124);
        tick();

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 9) == 0);
            pause = ($urandom_range(0, 3) == 0);
            tick();
        end
        pause = 1'b0;

        // Start held high: must not restart while busy, restarts out of DONE.
        start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (!compl_a) begin
                found = 1'b1;
                break;
            end
        end
        check("retrigger_reached_done_a", found, 1'b1);
        @(posedge clk);
        #1;
        check("retrigger_motor_a", motor_a, 2'b01);
        check("retrigger_busy_a", busy_a, 1'b1);
        check("retrigger_compl_n_a", compl_a, 1'b1);
        check("retrigger_cnt_a", cnt_a, 0);
        repeat (200) tick();
        start = 1'b0;
        repeat (130) tick();

        // Asynchronous reset in REV of cycle 1.
        pulse_start();
        repeat (5) tick();
        check("rev_before_reset_a", motor_a, 2'b10);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_motor_a", motor_a, 2'b00);
        check("async_reset_busy_a", busy_a, 1'b0);
        check("async_reset_compl_n_a", compl_a, 1'b1);
        check("async_reset_cnt_a", cnt_a, 0);
        check("async_reset_motor_b", motor_b, 2'b00);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_after_reset_a", busy_a, 1'b0);
        pulse_start();
        wait_done(200, ka, kb);
        check("post_reset_done_edge_a", ka, 16);
        check("post_reset_done_edge_b", kb, 120);

        @(negedge clk);
        #1;
        check("queue_drained", q_a.size() + q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
